// File: rtl/control_pkg.sv
// Shared definitions for the MIPS multi-cycle control sequencer: phases,
// trap cause codes and the default control-state numbering.
package control_pkg;

  typedef enum logic [2:0] {
    PH_RESET,
    PH_FETCH,
    PH_FETCH_WAIT,
    PH_IR_LOAD,
    PH_DECODE,
    PH_EXEC,
    PH_DATA_WAIT,
    PH_TRAP
  } phase_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'd2;
  localparam logic [1:0] CAUSE_DATA_TO  = 2'd3;

  localparam int DEF_LOAD_STATE  = 13;
  localparam int DEF_STORE_STATE = 7;
  localparam int DEF_TRAP_STATE  = 127;

  // Fixed numbers emitted by the phases that do not depend on the instruction.
  localparam int ST_RESET      = 0;
  localparam int ST_FETCH      = 1;
  localparam int ST_FETCH_WAIT = 2;
  localparam int ST_IR_LOAD    = 3;
  localparam int ST_DECODE     = 4;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/wait_timer.sv
// Wait-state timer: counts cycles since the wait began, remembers whether the
// awaited event has occurred, and flags when the allowed wait has run out.
module wait_timer
  import control_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic event_in,
  output logic seen,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count;
  logic               seen_q;

  // Cleared whenever idle so each wait starts from zero; saturates at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      seen_q <= 1'b0;
    end else if (!enable) begin
      count  <= '0;
      seen_q <= 1'b0;
    end else begin
      if (count != LAST) count <= count + TIMER_W'(1);
      seen_q <= seen_q | event_in;
    end
  end

  assign seen    = seen_q | (enable & event_in);
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/control_state_sequencer.sv
// Multi-cycle MIPS control sequencer: fetch, decode, execute and memory-wait
// phases with moc handshake timeout, stall and illegal-instruction trap.
module control_state_sequencer
  import control_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int EXEC_CYCLES = 1,
  parameter int MOC_TIMEOUT = 16,
  parameter int LOAD_STATE  = DEF_LOAD_STATE,
  parameter int STORE_STATE = DEF_STORE_STATE,
  parameter int TRAP_STATE  = DEF_TRAP_STATE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STATE_W-1:0] decode_state,
  input  logic               moc,
  input  logic               stall,
  input  logic               trap_clear,
  output logic [STATE_W-1:0] state,
  output logic               mem_req,
  output logic               mem_write,
  output logic               ir_load,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  localparam logic [STATE_W-1:0] LOAD_S    = STATE_W'(LOAD_STATE);
  localparam logic [STATE_W-1:0] STORE_S   = STATE_W'(STORE_STATE);
  localparam logic [STATE_W-1:0] TRAP_S    = STATE_W'(TRAP_STATE);
  localparam logic [3:0]         EXEC_LAST = 4'(EXEC_CYCLES - 1);

  phase_t             phase;
  phase_t             phase_d;
  logic [1:0]         cause_d;
  logic [STATE_W-1:0] exec_reg;
  logic [3:0]         exec_cnt;
  logic               in_wait;
  logic               moc_seen;
  logic               timed_out;
  logic               exec_done;
  logic               is_mem_op;
  logic               illegal;

  assign in_wait   = (phase == PH_FETCH_WAIT) || (phase == PH_DATA_WAIT);
  assign exec_done = (exec_cnt == EXEC_LAST);
  assign is_mem_op = (exec_reg == LOAD_S) || (exec_reg == STORE_S);
  assign illegal   = (decode_state == '0) || (decode_state >= TRAP_S);

  wait_timer #(
    .LIMIT(MOC_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (in_wait),
    .event_in(moc),
    .seen    (moc_seen),
    .expired (timed_out)
  );

  // A moc arriving on the expiry cycle is checked first, so it beats the trap.
  always_comb begin
    phase_d = phase;
    cause_d = trap_cause;
    unique case (phase)
      PH_RESET:      if (!stall) phase_d = PH_FETCH;
      PH_FETCH:      if (!stall) phase_d = PH_FETCH_WAIT;
      PH_FETCH_WAIT: begin
        if (!stall) begin
          if (moc_seen) begin
            phase_d = PH_IR_LOAD;
          end else if (timed_out) begin
            phase_d = PH_TRAP;
            cause_d = CAUSE_FETCH_TO;
          end
        end
      end
      PH_IR_LOAD:    if (!stall) phase_d = PH_DECODE;
      PH_DECODE: begin
        if (!stall) begin
          if (illegal) begin
            phase_d = PH_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            phase_d = PH_EXEC;
          end
        end
      end
      PH_EXEC: begin
        if (!stall && exec_done) phase_d = is_mem_op ? PH_DATA_WAIT : PH_FETCH;
      end
      PH_DATA_WAIT: begin
        if (!stall) begin
          if (moc_seen) begin
            phase_d = PH_FETCH;
          end else if (timed_out) begin
            phase_d = PH_TRAP;
            cause_d = CAUSE_DATA_TO;
          end
        end
      end
      PH_TRAP: begin
        if (trap_clear) begin
          phase_d = PH_FETCH;
          cause_d = CAUSE_NONE;
        end
      end
      default:       phase_d = PH_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= PH_RESET;
      trap_cause <= CAUSE_NONE;
      exec_reg   <= '0;
      exec_cnt   <= '0;
    end else begin
      phase      <= phase_d;
      trap_cause <= cause_d;
      if (phase == PH_DECODE && !stall && !illegal) exec_reg <= decode_state;
      if (phase == PH_DECODE) begin
        exec_cnt <= '0;
      end else if (phase == PH_EXEC && !stall && !exec_done) begin
        exec_cnt <= exec_cnt + 4'd1;
      end
    end
  end

  // Outputs decode straight from the registered phase, so reset clears them at once.
  always_comb begin
    state     = '0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    ir_load   = 1'b0;
    trap      = 1'b0;
    unique case (phase)
      PH_RESET:      state = STATE_W'(ST_RESET);
      PH_FETCH: begin
        state   = STATE_W'(ST_FETCH);
        mem_req = 1'b1;
      end
      PH_FETCH_WAIT: begin
        state   = STATE_W'(ST_FETCH_WAIT);
        mem_req = 1'b1;
      end
      PH_IR_LOAD: begin
        state   = STATE_W'(ST_IR_LOAD);
        ir_load = !stall;
      end
      PH_DECODE:     state = STATE_W'(ST_DECODE);
      PH_EXEC:       state = exec_reg;
      PH_DATA_WAIT: begin
        state     = exec_reg + STATE_W'(1);
        mem_req   = 1'b1;
        mem_write = (exec_reg == STORE_S);
      end
      PH_TRAP: begin
        state = TRAP_S;
        trap  = 1'b1;
      end
      default:       state = '0;
    endcase
  end

endmodule
